// File: rtl/spike_rate_monitor.sv
// spike_rate_monitor
//   Post-processing for a LIF neuron spike train. Detects spike rising edges,
//   counts them over a fixed window of WINDOW enabled cycles to form a
//   firing-rate sample, and measures the inter-spike interval between the two
//   most recent edges.
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   ena         enable; low freezes window/spike/ISI counters and masks edges
//   spike       spike level from the neuron (may be held high)
//   rate        spike count of the last completed window (saturates at 255)
//   rate_valid  rate holds an unconsumed sample
//   rate_ready  consumer accepts the sample when rate_valid & rate_ready
//   overrun     sticky: a completed window was dropped while a sample pended
//   isi         cycles between the two most recent edges (saturating)
//   isi_valid   at least two edges seen since reset
module spike_rate_monitor #(
  parameter int WINDOW = 1024,
  parameter int ISI_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             spike,
  output logic [7:0]       rate,
  output logic             rate_valid,
  input  logic             rate_ready,
  output logic             overrun,
  output logic [ISI_W-1:0] isi,
  output logic             isi_valid
);

  localparam int CNT_W = (WINDOW > 2) ? $clog2(WINDOW) : 1;
  localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WINDOW - 1);

  typedef enum logic {
    WAIT_FIRST,
    MEASURE
  } isi_state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [ISI_W-1:0] sat_inc_isi(input logic [ISI_W-1:0] v);
    return (&v) ? v : v + {{(ISI_W-1){1'b0}}, 1'b1};
  endfunction

  logic             spike_d;
  logic [CNT_W-1:0] win_cnt;
  logic [7:0]       spike_cnt;
  logic             spike_edge;
  logic             win_end;
  logic [7:0]       final_cnt;

  isi_state_t       state_q, state_d;
  logic [ISI_W-1:0] isi_cnt_q, isi_cnt_d;
  logic [ISI_W-1:0] isi_d;
  logic             isi_valid_d;

  assign spike_edge = spike & ~spike_d & ena;
  assign win_end    = ena && (win_cnt == WIN_LAST);
  // An edge landing in the window-end cycle belongs to the ending window.
  assign final_cnt  = spike_edge ? sat_inc8(spike_cnt) : spike_cnt;

  // Edge detection: spike_d tracks spike regardless of ena, so a spike that
  // rose while disabled is not counted when ena returns.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) spike_d <= 1'b0;
    else     spike_d <= spike;
  end

  // Window and spike counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_cnt   <= '0;
      spike_cnt <= 8'd0;
    end else if (ena) begin
      if (win_end) begin
        win_cnt   <= '0;
        spike_cnt <= 8'd0;
      end else begin
        win_cnt   <= win_cnt + CNT_W'(1);
        spike_cnt <= final_cnt;
      end
    end
  end

  // Sample publication and handshake. A window end may load a new sample in
  // the same cycle the previous one is consumed, keeping rate_valid high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rate       <= 8'd0;
      rate_valid <= 1'b0;
      overrun    <= 1'b0;
    end else if (win_end) begin
      if (!rate_valid || rate_ready) begin
        rate       <= final_cnt;
        rate_valid <= 1'b1;
      end else begin
        overrun    <= 1'b1;
      end
    end else if (rate_valid && rate_ready) begin
      rate_valid <= 1'b0;
    end
  end

  // ISI FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= WAIT_FIRST;
      isi_cnt_q <= '0;
      isi       <= '0;
      isi_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      isi_cnt_q <= isi_cnt_d;
      isi       <= isi_d;
      isi_valid <= isi_valid_d;
    end
  end

  // ISI FSM next state. The counter starts at 1 on an edge so that edges k
  // enabled cycles apart report exactly k.
  always_comb begin
    state_d     = state_q;
    isi_cnt_d   = isi_cnt_q;
    isi_d       = isi;
    isi_valid_d = isi_valid;
    case (state_q)
      WAIT_FIRST: begin
        if (spike_edge) begin
          isi_cnt_d = {{(ISI_W-1){1'b0}}, 1'b1};
          state_d   = MEASURE;
        end
      end
      MEASURE: begin
        if (spike_edge) begin
          isi_d       = isi_cnt_q;
          isi_valid_d = 1'b1;
          isi_cnt_d   = {{(ISI_W-1){1'b0}}, 1'b1};
        end else if (ena) begin
          isi_cnt_d   = sat_inc_isi(isi_cnt_q);
        end
      end
      default: state_d = WAIT_FIRST;
    endcase
  end

endmodule
